// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display with a
// double-buffered image. Define SEG_LZB_EN to enable leading-zero blanking.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LIT  = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [4*NUM_DIGITS-1:0] active_data;
  logic [NUM_DIGITS-1:0]   active_dp;
  logic [NUM_DIGITS-1:0]   active_blank;
  logic [NUM_DIGITS-1:0]   lzb_mask;

  logic                    slot_end;
  logic                    boundary;
  logic                    lit;
  logic                    accept;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   cur_an;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = 7'b1000000;
      4'h1:    hex_to_seg = 7'b1111001;
      4'h2:    hex_to_seg = 7'b0100100;
      4'h3:    hex_to_seg = 7'b0110000;
      4'h4:    hex_to_seg = 7'b0011001;
      4'h5:    hex_to_seg = 7'b0010010;
      4'h6:    hex_to_seg = 7'b0000010;
      4'h7:    hex_to_seg = 7'b1111000;
      4'h8:    hex_to_seg = 7'b0000000;
      4'h9:    hex_to_seg = 7'b0010000;
      4'hA:    hex_to_seg = 7'b0001000;
      4'hB:    hex_to_seg = 7'b0000011;
      4'hC:    hex_to_seg = 7'b1000110;
      4'hD:    hex_to_seg = 7'b0100001;
      4'hE:    hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  assign load_ready = !pending;
  assign accept     = load_valid && !pending;
  assign slot_end   = (cnt == CNT_LAST);
  assign boundary   = slot_end && (idx == IDX_LAST);
  assign lit        = (cnt >= CNT_LIT);

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_an    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = active_data[4*i +: 4];
        cur_dp    = active_dp[i];
        cur_blank = active_blank[i];
        cur_an[i] = 1'b0;
      end
    end
  end

`ifdef SEG_LZB_EN
  // A digit is blanked when it and every digit above it hold zero; digit 0 never is.
  always_comb begin
    logic seen_nz;
    seen_nz  = 1'b0;
    lzb_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      seen_nz     = seen_nz || (shadow_data[4*i +: 4] != 4'h0);
      lzb_mask[i] = !seen_nz;
    end
  end
`else
  assign lzb_mask = '0;
`endif

  // Commit and capture are mutually exclusive: capture needs pending low, commit needs it high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      idx          <= '0;
      pending      <= 1'b0;
      shadow_data  <= '0;
      shadow_dp    <= '0;
      active_data  <= '0;
      active_dp    <= '0;
      active_blank <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CNT_W'(1);
      if (slot_end) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
      if (boundary && pending) begin
        active_data  <= shadow_data;
        active_dp    <= shadow_dp;
        active_blank <= lzb_mask;
        pending      <= 1'b0;
      end else if (accept) begin
        shadow_data <= load_data;
        shadow_dp   <= load_dp;
        pending     <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= 7'h7F;
      dp         <= 1'b1;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      seg        <= (lit && !cur_blank) ? hex_to_seg(cur_nib) : 7'h7F;
      dp         <= lit ? !cur_dp : 1'b1;
      an         <= lit ? cur_an : '1;
      frame_tick <= boundary;
    end
  end

endmodule
